palindrome_gen: RTL and testbench

PALINDROME_GEN -- requirements
Module: palindrome_gen

---
 rtl/palindrome_pkg.sv | 27 ++
 rtl/palindrome_gen.sv | 89 ++++++++
 tb/tb_palindrome_gen.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the serial palindrome generator.
package palindrome_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam int WORD_COUNT_WIDTH = 16;

  // Widest half-word bitrev can handle; callers zero-extend into it.
  localparam int BITREV_MAX_WIDTH = 128;

  // Reverses a full BITREV_MAX_WIDTH vector. A narrower value placed in the
  // low bits ends up reversed in the top bits, so callers shift it back down.
  function automatic logic [BITREV_MAX_WIDTH-1:0] bitrev(
    input logic [BITREV_MAX_WIDTH-1:0] value
  );
    logic [BITREV_MAX_WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < BITREV_MAX_WIDTH; i++) begin
      result[BITREV_MAX_WIDTH-1-i] = value[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/palindrome_gen.sv
// Builds a palindrome {seed, bitrev(seed)} from each accepted seed and
// streams it out MSB first over a valid/ready serial interface.
module palindrome_gen
  import palindrome_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH/2-1:0]     din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic                        dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_last,
  output logic [WORD_COUNT_WIDTH-1:0] word_count
);

  localparam int HALF  = DATA_WIDTH / 2;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                      state;
  state_t                      state_next;
  logic [DATA_WIDTH-1:0]       shreg;
  logic [CNT_W-1:0]            bit_cnt;
  logic [WORD_COUNT_WIDTH-1:0] word_count_q;
  logic [HALF-1:0]             din_rev;
  logic                        accept;
  logic                        xfer;
  logic                        last_xfer;

  assign din_rev = HALF'(bitrev(BITREV_MAX_WIDTH'(din)) >> (BITREV_MAX_WIDTH - HALF));

  assign dout_valid = (state == SEND);
  assign dout       = (state == SEND) & shreg[DATA_WIDTH-1];
  assign dout_last  = (state == SEND) && (bit_cnt == LAST_BIT);
  assign din_ready  = (state == IDLE) || (dout_last && dout_ready);
  assign word_count = word_count_q;

  assign accept    = din_valid && din_ready;
  assign xfer      = dout_valid && dout_ready;
  assign last_xfer = xfer && dout_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A seed arriving with the last bit keeps us in SEND with no bubble.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SEND;
      SEND: begin
        if (accept) begin
          state_next = SEND;
        end else if (last_xfer) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      word_count_q <= '0;
    end else begin
      if (accept) begin
        shreg   <= {din, din_rev};
        bit_cnt <= '0;
      end else if (xfer) begin
        shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (last_xfer) begin
        word_count_q <= word_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_palindrome_gen.sv
// Scoreboard bench: words expected from a string-level palindrome model are
// queued at seed acceptance and compared by an independent output monitor.
module tb_palindrome_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic [15:0] word_count;

  logic [15:0] din_w;
  logic        din_valid_w;
  logic        din_ready_w;
  logic        dout_w;
  logic        dout_valid_w;
  logic        dout_ready_w;
  logic        dout_last_w;
  logic [15:0] word_count_w;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_wc       = '0;
  int          bits_seen    = 0;
  logic [7:0]  got_word     = '0;
  int          ready_mode   = 0;
  logic        prev_valid   = 1'b0;
  logic        prev_ready   = 1'b0;
  logic        prev_dout    = 1'b0;
  logic        prev_last    = 1'b0;

  always #5 clk = ~clk;

  palindrome_gen #(.DATA_WIDTH(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .word_count (word_count)
  );

  palindrome_gen #(.DATA_WIDTH(32)) dut32 (
    .clk        (clk),
    .reset      (reset),
    .din        (din_w),
    .din_valid  (din_valid_w),
    .din_ready  (din_ready_w),
    .dout       (dout_w),
    .dout_valid (dout_valid_w),
    .dout_ready (dout_ready_w),
    .dout_last  (dout_last_w),
    .word_count (word_count_w)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // The seed read MSB first, followed by the same seed read LSB first.
  function automatic logic [7:0] model_word(input logic [3:0] seed);
    bit         q[$];
    logic [7:0] w;
    for (int k = 3; k >= 0; k--) q.push_back(seed[k]);
    for (int k = 0; k < 4; k++) q.push_back(seed[k]);
    w = '0;
    foreach (q[j]) w = {w[6:0], q[j]};
    return w;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  // Monitor: assembles serial bits into words and checks stall behaviour.
  always @(negedge clk) begin
    if (reset) begin
      bits_seen  = 0;
      got_word   = '0;
      exp_q.delete();
      exp_wc     = '0;
      prev_valid = 1'b0;
    end else begin
      checkOutput("word_count", 32'(word_count), 32'(exp_wc));
      if (!dout_valid) checkOutput("idle_outputs", {30'd0, dout, dout_last}, 32'd0);
      if (prev_valid && !prev_ready)
        checkOutput("stall_hold", {29'd0, dout_valid, dout, dout_last},
                    {29'd0, 1'b1, prev_dout, prev_last});
      if (dout_valid && dout_ready) begin
        checkOutput("dout_last", 32'(dout_last), 32'(bits_seen == 7));
        got_word = {got_word[6:0], dout};
        bits_seen++;
        if (bits_seen == 8) begin
          if (exp_q.size() == 0) failNow("unexpected_word", $sformatf("got %0h, expected none", got_word));
          else checkOutput("word", 32'(got_word), 32'(exp_q.pop_front()));
          bits_seen = 0;
          exp_wc    = exp_wc + 16'd1;
        end
      end
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
    end
  end

  task automatic applyStimulus(input logic [3:0] seed);
    int waited = 0;
    bit done   = 1'b0;
    din       = seed;
    din_valid = 1'b1;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (din_ready && !reset) begin
        exp_q.push_back(model_word(seed));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (!done) failNow("accept_timeout", "got no din_ready, expected acceptance");
    din_valid = 1'b0;
    din       = 4'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || bits_seen != 0 || dout_valid) && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 2000) failNow("drain_timeout", $sformatf("got %0d words pending, expected 0", exp_q.size()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] word32;
    int          nbits;
    int          cyc;
    bit          got;

    reset        = 1'b1;
    din          = '0;
    din_valid    = 1'b0;
    dout_ready   = 1'b1;
    din_w        = '0;
    din_valid_w  = 1'b0;
    dout_ready_w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    checkOutput("reset_din_ready", 32'(din_ready), 32'd1);
    checkOutput("reset_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("reset_word_count", 32'(word_count), 32'd0);
    checkOutput("reset_din_ready_32", 32'(din_ready_w), 32'd1);
    @(posedge clk);
    #1;

    // Abandon a word after three bits.
    applyStimulus(4'hB);
    cyc = 0;
    while (bits_seen != 3 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 50) failNow("midword_timeout", "got fewer than 3 bits, expected 3");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("midreset_din_ready", 32'(din_ready), 32'd1);
    checkOutput("midreset_word_count", 32'(word_count), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(4'b1000);
    drain();
    checkOutput("single_word_count", 32'(word_count), 32'd1);

    // Two seeds with din_valid held: 16 contiguous bits, ready only on the last.
    applyStimulus(4'h6);
    din       = 4'h9;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("b2b_valid_first", 32'(dout_valid), 32'd1);
      checkOutput("b2b_din_ready", 32'(din_ready), 32'(i == 7));
      if (din_ready) exp_q.push_back(model_word(4'h9));
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("b2b_valid_second", 32'(dout_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    drain();
    checkOutput("b2b_word_count", 32'(word_count), 32'd3);

    ready_mode = 1;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(4'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    ready_mode = 0;
    checkOutput("random_word_count", 32'(word_count), 32'd33);

    force dut8.word_count_q = 16'hFFFF;
    exp_wc = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut8.word_count_q;
    @(posedge clk);
    #1;
    applyStimulus(4'($urandom));
    drain();
    checkOutput("wrap_word_count", 32'(word_count), 32'd0);

    // Wide instance: seed 16'hA000 must stream out as 32'hA0000005.
    din_w       = 16'hA000;
    din_valid_w = 1'b1;
    got         = 1'b0;
    cyc         = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      if (din_ready_w) got = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!got) failNow("accept32_timeout", "got no din_ready, expected acceptance");
    din_valid_w = 1'b0;
    word32 = '0;
    nbits  = 0;
    cyc    = 0;
    while (nbits < 32 && cyc < 100) begin
      @(negedge clk);
      if (dout_valid_w) begin
        if (nbits == 31) checkOutput("w32_last", 32'(dout_last_w), 32'd1);
        word32 = {word32[30:0], dout_w};
        nbits++;
      end
      cyc++;
    end
    if (nbits < 32) failNow("w32_timeout", $sformatf("got %0d bits, expected 32", nbits));
    checkOutput("w32_word", word32, 32'hA0000005);
    @(negedge clk);
    checkOutput("w32_word_count", 32'(word_count_w), 32'd1);
    checkOutput("w32_idle", 32'(dout_valid_w), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
